dma_rx_fl_framer: RTL and testbench
===================================

// Module: dma_rx_fl_framer
// PURPOSE
//  HW endpoint of the DPI send path: takes the raw 64-bit word stream written
//  by the host DMA channel (header word + payload) and rebuilds one FrameLink
//  frame per transfer for the DUT input. Sits between the DMA RX buffer and
//  the DUT. Checks header length, generates SOF/EOF/REM, drops bad transfers.
// PARAMETERS
//  DATA_WIDTH  64    word width, bits; multiple of 8, power of 2
//  MAX_LEN     1522  largest legal payload, bytes; must be < 2**16
// PORTS
//  CLK           in   1              single clock
//  RESET         in   1              asynchronous, active-low reset
//  RX_DATA       in   DATA_WIDTH     DMA word (header or payload)
//  RX_SRC_RDY    in   1              RX_DATA valid (active-high)
//  RX_DST_RDY    out  1              word accepted when SRC_RDY & DST_RDY
//  TX_DATA       out  DATA_WIDTH     FrameLink data
//  TX_REM        out  log2(DW/8)     index of last valid byte in word
//  TX_SOF_N      out  1              start of frame (= SOP_N, 1 part)
//  TX_SOP_N      out  1
//  TX_EOF_N      out  1              end of frame (= EOP_N)
//  TX_EOP_N      out  1
//  TX_SRC_RDY_N  out  1              TX word valid (active-low)
//  TX_DST_RDY_N  in   1              sink ready (active-low)
//  TX_TAG        out  8              header tag of frame on TX, held whole frame
//  ERR           out  1              1-cycle pulse per dropped transfer
//  FRAME_CNT     out  32             frames fully sent, wraps 2**32-1 -> 0
// BEHAVIOUR
//  Reset: FSM=HDR, RX_DST_RDY=0, TX_SRC_RDY_N/SOF_N/SOP_N/EOF_N/EOP_N=1,
//   TX_DATA/REM/TAG=0, ERR=0, FRAME_CNT=0. Takes effect immediately.
//   Frame in flight is abandoned, not completed. RX_DST_RDY=1 from the
//   first clock after release.
//  Header word: [15:0]=LEN bytes, [23:16]=TAG, rest ignored.
//   Payload = ceil(LEN/(DW/8)) words, byte 0 in bits [7:0].
//  FSM states HDR, DATA, DISCARD:
//   HDR: accept one word. LEN in 1..MAX_LEN -> latch TAG, remaining-word
//        counter=ceil(LEN/8), last_rem=(LEN-1) mod 8, go DATA, no TX.
//        LEN=0 -> ERR pulse next cycle, stay HDR.
//        LEN>MAX_LEN -> ERR pulse, counter=ceil(LEN/8), go DISCARD.
//   DATA: each accepted word -> output register. SOF/SOP_N=0 on the first
//        word. On the last word (counter==1): EOF/EOP_N=0, REM=last_rem,
//        then go HDR. All other words: REM=all-ones.
//   DISCARD: accept and drop counter words, RX_DST_RDY=1, no TX; then HDR.
//  Output register, 1 deep: RX_DST_RDY = (state!=DATA) | reg empty |
//   TX_DST_RDY_N==0. Latency RX accept -> TX valid = 1 cycle. Back-to-back
//   throughput 1 word/clk while the sink is ready. TX_DATA/REM/SOF/EOF stay
//   stable while TX_SRC_RDY_N=0 and TX_DST_RDY_N=1.
//  Header of the next transfer may be accepted the cycle after the last data
//   word, while that word is still waiting in the output register.
//   TX_TAG updates only when the new frame's SOF word loads. A tag shadow
//   register holds the pending tag.
//  FRAME_CNT increments on the EOF word handshake (SRC_RDY_N=0 & DST_RDY_N=0).
//  Bytes of the last word beyond REM are passed unchanged (don't-care).
//  Counter width 16-log2(DW/8)+1. No arithmetic overflow for LEN<=65535.
// STRUCTURE
//  dma_fl_pkg: HDR_LEN_LSB/MSB, HDR_TAG_LSB/MSB constants, state_t enum
//   {HDR,DATA,DISCARD}, function words_of(len, dw).
//  Sub-module fl_out_reg: 1-deep FrameLink register with SRC/DST_RDY_N
//   handshake, reused by other fl_tools edit blocks. Framer FSM in top.
// TESTING
//  LEN=8, TAG=0x5A, 1 word -> one TX word, SOF=EOF=0, REM=7, TAG=0x5A, CNT=1
//  LEN=13, 2 words, sink always ready -> words on 2 consecutive clks;
//   REM 7 then 4; SOF on word 1 only, EOF on word 2 only
//  LEN=0, then LEN=1 -> ERR pulse, no TX; then 1-word frame with REM=0
//  LEN=2000 (>MAX_LEN), 250 words, then LEN=64 -> ERR; 250 words dropped;
//   next frame is 8 words, REM=7, FRAME_CNT=1
//  LEN=64, TX_DST_RDY_N random 50% -> 8 words in order, stable while
//   stalled, RX_DST_RDY=0 only when the register is full and stalled
//  Reset asserted mid-frame (word 3 of 8), then LEN=16 -> outputs at reset
//   values at once; after release a clean 2-word frame, FRAME_CNT=1

Source files
------------

// File: rtl/dma_rx_fl_framer_pkg.sv
// Shared constants, state encoding and helpers for the DMA RX -> FrameLink framer.
package dma_rx_fl_framer_pkg;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;
  localparam int HDR_TAG_LSB = 16;
  localparam int HDR_TAG_MSB = 23;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    DATA    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  // Number of dw-bit words needed to carry len bytes; 17 bits so 65535 cannot overflow.
  function automatic logic [16:0] words_of(input logic [15:0] len, input int dw);
    logic [16:0] bpw;
    bpw = 17'(dw / 8);
    return ({1'b0, len} + bpw - 17'd1) / bpw;
  endfunction

endpackage

// File: rtl/dma_rx_fl_framer_if.sv
// DMA word stream in (active-high handshake) and FrameLink stream out (active-low handshake).
interface dma_rx_fl_framer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REM_W      = $clog2(DATA_WIDTH / 8)
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_src_rdy;
  logic                  rx_dst_rdy;

  logic [DATA_WIDTH-1:0] tx_data;
  logic [REM_W-1:0]      tx_rem;
  logic                  tx_sof_n;
  logic                  tx_sop_n;
  logic                  tx_eof_n;
  logic                  tx_eop_n;
  logic                  tx_src_rdy_n;
  logic                  tx_dst_rdy_n;
  logic [7:0]            tx_tag;

  modport slave (
    input  rx_data, rx_src_rdy, tx_dst_rdy_n,
    output rx_dst_rdy, tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eof_n, tx_eop_n,
           tx_src_rdy_n, tx_tag
  );

  modport master (
    output rx_data, rx_src_rdy, tx_dst_rdy_n,
    input  rx_dst_rdy, tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eof_n, tx_eop_n,
           tx_src_rdy_n, tx_tag
  );
endinterface

// File: rtl/dma_rx_fl_framer_fl_out_reg.sv
// One-deep FrameLink output register; refills in the same cycle it is drained.
module fl_out_reg #(
  parameter int DW    = 64,
  parameter int REM_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DW-1:0]    data_i,
  input  logic [REM_W-1:0] rem_i,
  input  logic             sof_i,
  input  logic             eof_i,
  output logic             ready_o,
  output logic [DW-1:0]    data_o,
  output logic [REM_W-1:0] rem_o,
  output logic             sof_n_o,
  output logic             eof_n_o,
  output logic             src_rdy_n_o,
  input  logic             dst_rdy_n_i
);

  logic             full_q;
  logic [DW-1:0]    data_q;
  logic [REM_W-1:0] rem_q;
  logic             sof_n_q;
  logic             eof_n_q;

  assign ready_o = !full_q || !dst_rdy_n_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
      sof_n_q <= 1'b1;
      eof_n_q <= 1'b1;
    end else if (load_i) begin
      full_q  <= 1'b1;
      data_q  <= data_i;
      rem_q   <= rem_i;
      sof_n_q <= !sof_i;
      eof_n_q <= !eof_i;
    end else if (full_q && !dst_rdy_n_i) begin
      // Data/REM keep their last value; only the frame markers are retired.
      full_q  <= 1'b0;
      sof_n_q <= 1'b1;
      eof_n_q <= 1'b1;
    end
  end

  assign data_o      = data_q;
  assign rem_o       = rem_q;
  assign sof_n_o     = sof_n_q;
  assign eof_n_o     = eof_n_q;
  assign src_rdy_n_o = !full_q;

endmodule

// File: rtl/dma_rx_fl_framer.sv
// Rebuilds one FrameLink frame per DMA transfer (header word + payload), dropping bad lengths.
//  state   | meaning
//  HDR     | waiting for header word; checks LEN, latches TAG / word count
//  DATA    | forwarding payload words into the output register
//  DISCARD | swallowing payload of an oversize transfer
module dma_rx_fl_framer
  import dma_rx_fl_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LEN    = 1522
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_rx_fl_framer_if.slave   bus,
  output logic                err_o,
  output logic [31:0]         frame_cnt_o
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int REM_W = $clog2(BPW);
  localparam int CNT_W = 16 - REM_W + 1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W-1:0] last_rem_q;
  logic [7:0]       tag_sh_q;
  logic [7:0]       tx_tag_q;
  logic             first_q;
  logic             err_q;
  logic             rdy_en_q;
  logic [31:0]      frame_cnt_q;

  logic [15:0]      hdr_len;
  logic [7:0]       hdr_tag;
  logic [CNT_W-1:0] hdr_words;
  logic             out_ready;
  logic             acc;
  logic             load;
  logic             last;
  logic [REM_W-1:0] out_rem;
  logic             tx_sof_n;
  logic             tx_eof_n;
  logic             tx_src_rdy_n;

  assign hdr_len   = bus.rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_tag   = bus.rx_data[HDR_TAG_MSB:HDR_TAG_LSB];
  assign hdr_words = CNT_W'(words_of(hdr_len, DATA_WIDTH));

  // rdy_en_q keeps RX closed during reset and opens it one clock after release.
  assign bus.rx_dst_rdy = rdy_en_q && ((state_q != DATA) || out_ready);
  assign acc            = bus.rx_src_rdy && bus.rx_dst_rdy;
  assign load           = acc && (state_q == DATA);
  assign last           = (cnt_q == CNT_W'(1));
  assign out_rem        = last ? last_rem_q : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      cnt_q       <= '0;
      last_rem_q  <= '0;
      tag_sh_q    <= '0;
      tx_tag_q    <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      err_q    <= 1'b0;
      if (!tx_src_rdy_n && !bus.tx_dst_rdy_n && !tx_eof_n)
        frame_cnt_q <= frame_cnt_q + 32'd1;
      // The pending tag stays shadowed until the new frame's SOF word loads.
      if (load && first_q)
        tx_tag_q <= tag_sh_q;
      case (state_q)
        HDR: begin
          if (acc) begin
            if (hdr_len == 16'd0) begin
              err_q <= 1'b1;
            end else if (hdr_len > 16'(MAX_LEN)) begin
              err_q   <= 1'b1;
              cnt_q   <= hdr_words;
              state_q <= DISCARD;
            end else begin
              tag_sh_q   <= hdr_tag;
              cnt_q      <= hdr_words;
              last_rem_q <= REM_W'(hdr_len - 16'd1);
              first_q    <= 1'b1;
              state_q    <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (last) state_q <= HDR;
          end
        end
        DISCARD: begin
          if (acc) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) state_q <= HDR;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  fl_out_reg #(
    .DW    (DATA_WIDTH),
    .REM_W (REM_W)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .data_i      (bus.rx_data),
    .rem_i       (out_rem),
    .sof_i       (first_q),
    .eof_i       (last),
    .ready_o     (out_ready),
    .data_o      (bus.tx_data),
    .rem_o       (bus.tx_rem),
    .sof_n_o     (tx_sof_n),
    .eof_n_o     (tx_eof_n),
    .src_rdy_n_o (tx_src_rdy_n),
    .dst_rdy_n_i (bus.tx_dst_rdy_n)
  );

  assign bus.tx_sof_n     = tx_sof_n;
  assign bus.tx_sop_n     = tx_sof_n;
  assign bus.tx_eof_n     = tx_eof_n;
  assign bus.tx_eop_n     = tx_eof_n;
  assign bus.tx_src_rdy_n = tx_src_rdy_n;
  assign bus.tx_tag       = tx_tag_q;
  assign err_o            = err_q;
  assign frame_cnt_o      = frame_cnt_q;

endmodule

// File: tb/tb_dma_rx_fl_framer.sv
// Directed bench for dma_rx_fl_framer: transfer table plus back-to-back tag and mid-frame reset cases.
module tb_dma_rx_fl_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err;
  logic [31:0] frame_cnt;

  always #5 clk = ~clk;

  dma_rx_fl_framer_if ifc ();

  dma_rx_fl_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc.slave),
    .err_o       (err),
    .frame_cnt_o (frame_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [2:0]  rem;
    logic        sof_n, sop_n, eof_n, eop_n;
    logic [7:0]  tag;
    int          cyc;
  } txw_t;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  tag;
    int          stall;
    int          exp_err;
    int          exp_words;
    logic [2:0]  exp_rem;
    int          exp_cnt;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   err_seen = 0;
  int   mode = 0;
  bit   chk_rdy = 1'b0;
  txw_t q[$];
  txw_t prev;
  bit   prev_stall = 1'b0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pdat(input int v, input int w);
    return {16'hD00D, 16'(v), 16'hBEEF, 16'(w)};
  endfunction

  always @(posedge clk) cyc++;

  // Sink: 0 = always ready, 1 = random 50%, 2 = held off.
  always @(negedge clk) begin
    if (mode == 0)      ifc.tx_dst_rdy_n = 1'b0;
    else if (mode == 1) ifc.tx_dst_rdy_n = 1'($urandom_range(0, 1));
    else                ifc.tx_dst_rdy_n = 1'b1;
  end

  // Monitor samples one time unit before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (err) err_seen++;
      if (prev_stall) begin
        chk("stall_data_stable", ifc.tx_data, prev.data);
        chk("stall_ctl_stable", {ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_eof_n, ifc.tx_rem},
            {1'b0, prev.sof_n, prev.eof_n, prev.rem});
      end
      if (chk_rdy && !ifc.rx_dst_rdy)
        chk("rx_rdy_low_only_full_stalled", {ifc.tx_src_rdy_n, ifc.tx_dst_rdy_n}, 2'b01);
      if (!ifc.tx_src_rdy_n && !ifc.tx_dst_rdy_n)
        q.push_back('{ifc.tx_data, ifc.tx_rem, ifc.tx_sof_n, ifc.tx_sop_n, ifc.tx_eof_n,
                      ifc.tx_eop_n, ifc.tx_tag, cyc});
      prev_stall = !ifc.tx_src_rdy_n && ifc.tx_dst_rdy_n;
      prev = '{ifc.tx_data, ifc.tx_rem, ifc.tx_sof_n, ifc.tx_sop_n, ifc.tx_eof_n,
               ifc.tx_eop_n, ifc.tx_tag, cyc};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_word(input logic [63:0] d, output int waited);
    ifc.rx_data    = d;
    ifc.rx_src_rdy = 1'b1;
    waited         = 0;
    #1;
    while (!ifc.rx_dst_rdy && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 300) chk("send_timeout", 64'(waited), 64'd0);
    @(negedge clk);
    ifc.rx_src_rdy = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] len, input logic [7:0] tag);
    int w;
    send_word({40'h0, tag, len}, w);
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int v, input logic [7:0] tag,
                             input int exp_words, input logic [2:0] exp_rem, input bit b2b);
    chk({nm, "_nwords"}, 64'(q.size()), 64'(exp_words));
    for (int i = 0; i < q.size() && i < exp_words; i++) begin
      logic       is_first, is_last;
      logic [2:0] rem_e;
      is_first = (i == 0);
      is_last  = (i == exp_words - 1);
      rem_e    = is_last ? exp_rem : 3'd7;
      chk($sformatf("%s_w%0d_data", nm, i), q[i].data, pdat(v, i));
      chk($sformatf("%s_w%0d_ctl", nm, i),
          {q[i].sof_n, q[i].sop_n, q[i].eof_n, q[i].eop_n, q[i].rem},
          {!is_first, !is_first, !is_last, !is_last, rem_e});
      chk($sformatf("%s_w%0d_tag", nm, i), q[i].tag, tag);
      if (b2b && i > 0)
        chk($sformatf("%s_w%0d_gap", nm, i), 64'(q[i].cyc - q[i-1].cyc), 64'd1);
    end
  endtask

  initial begin
    int wt, nw, err_base;
    ifc.rx_data    = '0;
    ifc.rx_src_rdy = 1'b0;

    vecs[0] = '{16'd8,    8'h5A, 0, 0, 1, 3'd7, 1};
    vecs[1] = '{16'd13,   8'h33, 0, 0, 2, 3'd4, 2};
    vecs[2] = '{16'd0,    8'h11, 0, 1, 0, 3'd0, 2};
    vecs[3] = '{16'd1,    8'h22, 0, 0, 1, 3'd0, 3};
    vecs[4] = '{16'd2000, 8'h44, 0, 1, 0, 3'd0, 3};
    vecs[5] = '{16'd64,   8'h66, 0, 0, 8, 3'd7, 4};
    vecs[6] = '{16'd64,   8'h77, 1, 0, 8, 3'd7, 5};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_rdy", ifc.rx_dst_rdy, 1'b0);
    chk("rst_tx_ctl", {ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_sop_n, ifc.tx_eof_n, ifc.tx_eop_n}, 5'h1F);
    chk("rst_tx_data_rem_tag", {ifc.tx_data[39:0], ifc.tx_rem, ifc.tx_tag}, 51'h0);
    chk("rst_err_cnt", {err, frame_cnt}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rx_rdy_before_first_clk", ifc.rx_dst_rdy, 1'b0);
    @(negedge clk);
    #1;
    chk("rx_rdy_after_release", ifc.rx_dst_rdy, 1'b1);

    for (int v = 0; v < 7; v++) begin
      mode     = vecs[v].stall;
      chk_rdy  = (vecs[v].stall == 1);
      err_base = err_seen;
      q.delete();
      send_hdr(vecs[v].len, vecs[v].tag);
      nw = (int'(vecs[v].len) + 7) / 8;
      for (int w = 0; w < nw; w++) send_word(pdat(v, w), wt);
      wait_words(vecs[v].exp_words);
      check_frame($sformatf("v%0d", v), v, vecs[v].tag, vecs[v].exp_words, vecs[v].exp_rem,
                  vecs[v].stall == 0);
      chk($sformatf("v%0d_err", v), 64'(err_seen - err_base), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_frame_cnt", v), frame_cnt, 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_drained", v), ifc.tx_src_rdy_n, 1'b1);
    end
    mode    = 0;
    chk_rdy = 1'b0;

    // Next header accepted while the previous frame's last word is still held.
    q.delete();
    err_base = err_seen;
    mode = 2;
    send_hdr(16'd8, 8'hA1);
    send_word(64'h1111_2222_3333_4444, wt);
    send_word({40'h0, 8'hB2, 16'd8}, wt);
    chk("b2b_hdr_wait", 64'(wt), 64'd0);
    #1;
    chk("b2b_tag_held", ifc.tx_tag, 8'hA1);
    chk("b2b_reg_full", {ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_eof_n}, 3'b000);
    ifc.rx_data    = 64'h5555_6666_7777_8888;
    ifc.rx_src_rdy = 1'b1;
    #1;
    chk("b2b_rx_blocked", ifc.rx_dst_rdy, 1'b0);
    ifc.rx_src_rdy = 1'b0;
    mode = 0;
    @(negedge clk);
    send_word(64'h5555_6666_7777_8888, wt);
    wait_words(2);
    chk("b2b_nwords", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      chk("b2b_w0", {q[0].data, q[0].tag, q[0].sof_n, q[0].eof_n, q[0].rem},
          {64'h1111_2222_3333_4444, 8'hA1, 1'b0, 1'b0, 3'd7});
      chk("b2b_w1", {q[1].data, q[1].tag, q[1].sof_n, q[1].eof_n, q[1].rem},
          {64'h5555_6666_7777_8888, 8'hB2, 1'b0, 1'b0, 3'd7});
    end
    chk("b2b_frame_cnt", frame_cnt, 32'd7);
    chk("b2b_err", 64'(err_seen - err_base), 64'd0);

    // Reset in the middle of a frame, then a clean frame.
    q.delete();
    send_hdr(16'd64, 8'h88);
    for (int w = 0; w < 3; w++) send_word(pdat(8, w), wt);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_rdy", ifc.rx_dst_rdy, 1'b0);
    chk("mid_rst_tx_ctl", {ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_sop_n, ifc.tx_eof_n, ifc.tx_eop_n}, 5'h1F);
    chk("mid_rst_data", ifc.tx_data, 64'h0);
    chk("mid_rst_rem_tag", {ifc.tx_rem, ifc.tx_tag}, 11'h0);
    chk("mid_rst_err_cnt", {err, frame_cnt}, 33'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy_before_clk", ifc.rx_dst_rdy, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst_rdy_after", ifc.rx_dst_rdy, 1'b1);
    q.delete();
    err_base = err_seen;
    send_hdr(16'd16, 8'h99);
    for (int w = 0; w < 2; w++) send_word(pdat(9, w), wt);
    wait_words(2);
    check_frame("post_rst", 9, 8'h99, 2, 3'd7, 1'b1);
    chk("post_rst_frame_cnt", frame_cnt, 32'd1);
    chk("post_rst_err", 64'(err_seen - err_base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
